// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encryption datapath: one round per clock, round key supplied by an external expander.
// Optional abort input enabled by defining AES_ABORT_EN.
module aes256_encrypt_core #(
   parameter int unsigned NR    = 14,
   parameter int unsigned CTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef AES_ABORT_EN
   input  logic             abort,
`endif
   input  logic [127:0]     plaintext,
   input  logic [127:0]     round_key,
   output logic [CTR_W-1:0] round_idx,
   output logic             busy,
   output logic             done,
   output logic [127:0]     ciphertext
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // One cipher round; byte i of a block sits at bits [127-8i -: 8], byte i = row (i%4), column (i/4)
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [127:0] sb;
      logic [127:0] sr;
      logic [127:0] mc;
      logic [7:0]   a0, a1, a2, a3;
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[127-32*c -: 8];
         a1 = sr[119-32*c -: 8];
         a2 = sr[111-32*c -: 8];
         a3 = sr[103-32*c -: 8];
         mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return (last ? sr : mc) ^ k;
   endfunction

   logic [0:0]       fsm_q, fsm_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [127:0]     state_q, state_d;
   logic [127:0]     ct_q, ct_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             last_round;
   logic [127:0]     round_out;

   assign last_round = (ctr_q == CTR_W'(NR));
   assign round_out  = aes_round(state_q, round_key, last_round);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         ctr_q   <= '0;
         state_q <= '0;
         ct_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         ctr_q   <= ctr_d;
         state_q <= state_d;
         ct_q    <= ct_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      ctr_d   = ctr_q;
      state_d = state_q;
      ct_d    = ct_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start) begin
               state_d = plaintext ^ round_key;
               ctr_d   = CTR_W'(1);
               busy_d  = 1'b1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            ctr_d   = ctr_q + CTR_W'(1);
            if (last_round) begin
               ct_d   = round_out;
               done_d = 1'b1;
               busy_d = 1'b0;
               ctr_d  = '0;
               fsm_d  = IDLE;
            end
`ifdef AES_ABORT_EN
            // Abort wins over completion and discards everything computed so far
            if (abort) begin
               state_d = '0;
               ct_d    = '0;
               ctr_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               fsm_d   = IDLE;
            end
`endif
         end
         default: fsm_d = IDLE;
      endcase
   end

   // Counter is held at 0 in IDLE, so it doubles as the key index in both states
   assign round_idx  = ctr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Scoreboard bench for aes256_encrypt_core; the bench plays the AES-256 key expander.
module tb_aes256_encrypt_core;

   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

   localparam logic [7:0] SB [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef struct {
      logic [127:0] ct;
      int           e0;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [127:0] plaintext;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         busy;
   logic         done;
   logic [127:0] ciphertext;

   logic [127:0] rk [15];
   exp_t         exp_q [$];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   aes256_encrypt_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
`ifdef AES_ABORT_EN
      .abort      (abort),
`endif
      .plaintext  (plaintext),
      .round_key  (round_key),
      .round_idx  (round_idx),
      .busy       (busy),
      .done       (done),
      .ciphertext (ciphertext)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Same-cycle combinational key return, as the real expander would provide
   always_comb round_key = (round_idx <= 4'd14) ? rk[round_idx] : 128'h0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
   endfunction

   // AES-256 key schedule: 60 words, round key r = words 4r..4r+3
   task automatic set_key(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
         else if (i % 8 == 4) t = subw(t);
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push(input logic [127:0] ct);
      exp_t e;
      e.ct = ct;
      e.e0 = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: no done within %0d cycles", n);
      end
   endtask

   // Called at a negedge with the core idle; returns in the done cycle
   task automatic run_block(input logic [255:0] key, input logic [127:0] pt, input logic [127:0] ct);
      set_key(key);
      plaintext = pt;
      start     = 1'b1;
      push(ct);
      @(negedge clk);
      start = 1'b0;
      wait_done();
   endtask

   // Scoreboard monitor: every done pops one expected block
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ciphertext", ciphertext, e.ct);
            check("latency", 128'(cyc - e.e0), 128'(14));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      plaintext = '0;
      set_key('0);
      repeat (2) @(negedge clk);
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      check("reset_ct", ciphertext, 128'h0);
      check("reset_idx", 128'(round_idx), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // C.3 with round_idx walk, a busy start pulse and a plaintext change after E0
      set_key(KEY_C3);
      plaintext = PT_C3;
      start = 1'b1;
      push(CT_C3);
      @(negedge clk);
      start = 1'b0;
      plaintext = 128'hffffffffffffffffffffffffffffffff;
      check("state_after_e0", dut.state_q, 128'h00102030405060708090a0b0c0d0e0f0);
      check("idx_1", 128'(round_idx), 128'(1));
      check("busy_run", 128'(busy), 128'(1));
      for (int i = 2; i <= 14; i++) begin
         if (i == 5) begin
            start = 1'b1;
            plaintext = '0;
         end
         if (i == 7) start = 1'b0;
         @(negedge clk);
         check($sformatf("idx_%0d", i), 128'(round_idx), 128'(i));
      end
      check("done_before_last", 128'(done), 128'(0));
      @(negedge clk);
      check("idx_done", 128'(round_idx), 128'(0));
      check("busy_done", 128'(busy), 128'(0));
      @(negedge clk);
      check("done_one_cycle", 128'(done), 128'(0));
      check("ct_hold", ciphertext, CT_C3);

      // All-zero key and plaintext
      run_block('0, '0, CT_Z);
      @(negedge clk);

      // Start held high: accepted at E0 and in each done cycle, alternating vectors
      set_key(KEY_C3);
      plaintext = PT_C3;
      start = 1'b1;
      push(CT_C3);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         wait_done();
         if (b < 3) begin
            set_key((b % 2 == 0) ? 256'h0 : KEY_C3);
            plaintext = (b % 2 == 0) ? 128'h0 : PT_C3;
            push((b % 2 == 0) ? CT_Z : CT_C3);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);

      // Synchronous reset mid-run
      set_key(KEY_C3);
      plaintext = PT_C3;
      start = 1'b1;
      push(CT_C3);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (round_idx != 4'd7 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reached_ctr7", 128'(round_idx), 128'(7));
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_mid_busy", 128'(busy), 128'(0));
      check("rst_mid_done", 128'(done), 128'(0));
      check("rst_mid_ct", ciphertext, 128'h0);
      check("rst_mid_idx", 128'(round_idx), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      run_block(KEY_C3, PT_C3, CT_C3);
      @(negedge clk);

`ifdef AES_ABORT_EN
      // Abort at counter 5 drops the block entirely
      set_key(KEY_C3);
      plaintext = PT_C3;
      start = 1'b1;
      push(CT_C3);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_at_ctr5", 128'(round_idx), 128'(5));
      abort = 1'b1;
      exp_q.delete();
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_done", 128'(done), 128'(0));
      check("abort_ct", ciphertext, 128'h0);
      repeat (16) @(negedge clk);
      run_block(KEY_C3, PT_C3, CT_C3);
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
